// File: rtl/uart_hub_pkg.sv
// uart_hub shared constants and FSM encodings.
// UART_HUB_PARITY_EN adds the even-parity states.
package uart_hub_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_RXV  = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FE   = 3;
  localparam int ST_PE   = 4;
  localparam int ST_W    = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_HUB_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_HUB_PARITY_EN
    RX_PAR,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_hub_ch.sv
// One full-duplex UART channel: TX/RX FSMs, sync, data regs, flags.
// UART_HUB_PARITY_EN adds even parity on both directions.
module uart_hub_ch
  import uart_hub_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            send,
  input  logic            wr_tx,
  input  logic            rd_rx,
  input  logic [7:0]      wdata,
  input  logic            rx,
  output logic            tx,
  output logic            irq,
  output logic [ST_W-1:0] status,
  output logic [7:0]      txdata,
  output logic [7:0]      rxdata
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  tx_state_t      tx_st, tx_nx;
  logic [CW-1:0]  tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_sh;
  logic           tx_tick;
`ifdef UART_HUB_PARITY_EN
  logic           tx_par;
`endif

  assign tx_tick = tx_cnt == LAST;

  always_comb begin
    tx_nx = tx_st;
    unique case (tx_st)
      TX_IDLE:  if (send) tx_nx = TX_START;
      TX_START: if (tx_tick) tx_nx = TX_DATA;
      TX_DATA:
        if (tx_tick && tx_bit == 3'd7) begin
`ifdef UART_HUB_PARITY_EN
          tx_nx = TX_PAR;
`else
          tx_nx = TX_STOP;
`endif
        end
`ifdef UART_HUB_PARITY_EN
      TX_PAR:   if (tx_tick) tx_nx = TX_STOP;
`endif
      TX_STOP:  if (tx_tick) tx_nx = TX_IDLE;
      default:  tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      txdata <= '0;
`ifdef UART_HUB_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else begin
      tx_st <= tx_nx;
      if (wr_tx) txdata <= wdata;
      if (tx_st == TX_IDLE || tx_tick) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 1'b1;
      // Shifter keeps its own copy so TXDATA writes never disturb a frame
      if (tx_st == TX_IDLE && send) begin
        tx_sh  <= txdata;
        tx_bit <= '0;
`ifdef UART_HUB_PARITY_EN
        tx_par <= ^txdata;
`endif
      end else if (tx_st == TX_DATA && tx_tick) begin
        tx_sh  <= tx_sh >> 1;
        tx_bit <= tx_bit + 1'b1;
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (tx_st)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_sh[0];
`ifdef UART_HUB_PARITY_EN
      TX_PAR:   tx = tx_par;
`endif
      default:  tx = 1'b1;
    endcase
  end

  rx_state_t      rx_st, rx_nx;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_sh;
  logic           s1, s2, rx_d;
  logic           rx_tick, rx_half, done;
  logic           rx_valid, rx_ovr, rx_fe;
`ifdef UART_HUB_PARITY_EN
  logic           rx_pe, par_err;
`endif

  assign rx_tick = rx_cnt == LAST;
  assign rx_half = rx_cnt == HALF;
  assign done    = rx_st == RX_STOP && rx_tick;

  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      RX_IDLE:  if (rx_d && !s2) rx_nx = RX_START;
      RX_START: if (rx_half) rx_nx = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_tick && rx_bit == 3'd7) begin
`ifdef UART_HUB_PARITY_EN
          rx_nx = RX_PAR;
`else
          rx_nx = RX_STOP;
`endif
        end
`ifdef UART_HUB_PARITY_EN
      RX_PAR:   if (rx_tick) rx_nx = RX_STOP;
`endif
      RX_STOP:  if (rx_tick) rx_nx = RX_IDLE;
      default:  rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      rx_d     <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rxdata   <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_fe    <= 1'b0;
`ifdef UART_HUB_PARITY_EN
      rx_pe    <= 1'b0;
      par_err  <= 1'b0;
`endif
    end else begin
      s1    <= rx;
      s2    <= s1;
      rx_d  <= s2;
      rx_st <= rx_nx;
      // Restart the count at mid-start so later samples land mid-bit
      if (rx_st == RX_IDLE || rx_tick || (rx_st == RX_START && rx_half))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_st == RX_START) rx_bit <= '0;
      if (rx_st == RX_DATA && rx_tick) begin
        rx_sh  <= {s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
`ifdef UART_HUB_PARITY_EN
      if (rx_st == RX_PAR && rx_tick) rx_pe <= s2 ^ (^rx_sh);
`endif
      // A completing frame outranks a same-cycle RXDATA read
      if (done) begin
        rxdata   <= rx_sh;
        rx_valid <= 1'b1;
        rx_ovr   <= (rx_ovr | rx_valid) & ~rd_rx;
        rx_fe    <= (rx_fe & ~rd_rx) | ~s2;
`ifdef UART_HUB_PARITY_EN
        par_err  <= (par_err & ~rd_rx) | rx_pe;
`endif
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
        rx_ovr   <= 1'b0;
        rx_fe    <= 1'b0;
`ifdef UART_HUB_PARITY_EN
        par_err  <= 1'b0;
`endif
      end
    end
  end

  assign irq = rx_valid;

  always_comb begin
    status          = '0;
    status[ST_BUSY] = tx_st != TX_IDLE;
    status[ST_RXV]  = rx_valid;
    status[ST_OVR]  = rx_ovr;
    status[ST_FE]   = rx_fe;
`ifdef UART_HUB_PARITY_EN
    status[ST_PE]   = par_err;
`else
    status[ST_PE]   = 1'b0;
`endif
  end

endmodule

// File: rtl/uart_hub.sv
// N-channel memory-mapped UART hub: address decode and read mux.
// Define UART_HUB_PARITY_EN for 11-bit even-parity frames.
module uart_hub
  import uart_hub_pkg::*;
#(
  parameter int N_CH   = 3,
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200,
  parameter int ADDR_W = $clog2(N_CH) + 2
) (
  input  logic              clk_100m_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic [N_CH-1:0]   rx_i,
  output logic [N_CH-1:0]   tx_o,
  output logic [N_CH-1:0]   irq_o
);

  localparam int DIV = CLK_HZ / BAUD;

  logic [ADDR_W-1:0] ch_idx;
  logic [1:0]        reg_sel;
  logic              unused_wdata;

  assign ch_idx       = addr_i >> 2;
  assign reg_sel      = addr_i[1:0];
  assign unused_wdata = ^wdata_i[31:8];

  logic [ST_W-1:0] st  [N_CH];
  logic [7:0]      txd [N_CH];
  logic [7:0]      rxd [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel;
    assign sel = ch_idx == ADDR_W'(i);

    uart_hub_ch #(
      .DIV(DIV)
    ) u_ch (
      .clk   (clk_100m_i),
      .rst_n (rst_n_i),
      .send  (we_i & sel & (reg_sel == REG_CTRL) & wdata_i[0]),
      .wr_tx (we_i & sel & (reg_sel == REG_TXDATA)),
      .rd_rx (re_i & sel & (reg_sel == REG_RXDATA)),
      .wdata (wdata_i[7:0]),
      .rx    (rx_i[i]),
      .tx    (tx_o[i]),
      .irq   (irq_o[i]),
      .status(st[i]),
      .txdata(txd[i]),
      .rxdata(rxd[i])
    );
  end

  // Out-of-range channels match no index and read as zero
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_idx == ADDR_W'(i)) begin
        case (reg_sel)
          REG_STATUS: rdata_o = 32'(st[i]);
          REG_TXDATA: rdata_o = 32'(txd[i]);
          REG_RXDATA: rdata_o = 32'(rxd[i]);
          default:    rdata_o = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_hub.sv
// Scoreboard bench for uart_hub: serial-line and irq monitors
// check against queued expectations; bus reads checked inline.
module tb_uart_hub;

  localparam int DIV = 868;
`ifdef UART_HUB_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic [2:0]  rx, tx, irq;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [10:0] tx_q [3][$];
  int          irq_q [3][$];

  uart_hub #(
    .N_CH(3),
    .CLK_HZ(100_000_000),
    .BAUD(115_200)
  ) dut (
    .clk_100m_i(clk),
    .rst_n_i   (rst_n),
    .we_i      (we),
    .re_i      (re),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .rx_i      (rx),
    .tx_o      (tx),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] tx_frame(logic [7:0] b);
`ifdef UART_HUB_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b01, b, 1'b0};
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_until(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(int c, int r, logic [31:0] d);
    @(negedge clk);
    addr  = 4'(c * 4 + r);
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input int c, input int r, input bit side,
                    output logic [31:0] d);
    @(negedge clk);
    addr = 4'(c * 4 + r);
    re   = side;
    #1 d = rdata;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic tx_send(int c, logic [7:0] b, bit upd, logic [7:0] b2);
    logic [31:0] d;
    int t0;
    wr(c, 2, {24'd0, b});
    tx_q[c].push_back(tx_frame(b));
    wr(c, 0, 32'd1);
    t0 = cyc;
    rd(c, 1, 1'b0, d);
    chk("tx_busy_set", {31'd0, d[0]}, 32'd1);
    if (upd) begin
      wait_until(t0 + 1000);
      wr(c, 2, {24'd0, b2});
      rd(c, 2, 1'b0, d);
      chk("txdata_update_busy", d, {24'd0, b2});
    end
    wait_until(t0 + FL - 2);
    rd(c, 1, 1'b0, d);
    chk("tx_busy_hold", {31'd0, d[0]}, 32'd1);
    rd(c, 1, 1'b0, d);
    chk("tx_busy_clear", {31'd0, d[0]}, 32'd0);
  endtask

  task automatic drive_rx(int c, logic [7:0] b, logic stop,
                          logic badpar, bit rise);
    logic [10:0] bits;
`ifdef UART_HUB_PARITY_EN
    bits = {stop, (^b) ^ badpar, b, 1'b0};
`else
    bits = {1'b0, stop, b, 1'b0};
`endif
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      if (k == NB - 1 && rise) irq_q[c].push_back(cyc + DIV / 2);
      rx[c] = bits[k];
      repeat (DIV) @(negedge clk);
    end
    rx[c] = 1'b1;
  endtask

  task automatic tx_mon(int c);
    logic [10:0] got, exp, mask;
    int n;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || tx[c] !== 1'b0) continue;
      got = '0;
      n = 0;
      ab = 1'b0;
      for (int k = 0; k < NB && !ab; k++) begin
        int w;
        w = (k == 0) ? DIV / 2 : DIV;
        for (int j = 0; j < w; j++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) ab = 1'b1;
        end
        if (!ab) begin
          got[k] = tx[c];
          n++;
        end
      end
      if (tx_q[c].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected_frame ch%0d: got 0x%0h, expected none",
                 c, got);
      end else begin
        exp = tx_q[c].pop_front();
        mask = (n >= 11) ? 11'h7ff : (11'(1) << n) - 11'd1;
        if (n > 0) chk($sformatf("tx_frame_ch%0d", c), 32'(got & mask),
                       32'(exp & mask));
      end
      if (ab) wait (rst_n === 1'b1);
    end
  endtask

  task automatic irq_mon();
    logic [2:0] prev;
    int m, d;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev = '0;
        continue;
      end
      for (int c = 0; c < 3; c++) begin
        if (irq[c] === 1'b1 && !prev[c]) begin
          checks++;
          if (irq_q[c].size() == 0) begin
            errors++;
            $display("FAIL irq_unexpected ch%0d: got rise at %0d, expected none",
                     c, cyc);
          end else begin
            m = irq_q[c].pop_front();
            d = cyc - m;
            if (d < 0 || d > DIV / 2 + 3) begin
              errors++;
              $display("FAIL irq_latency ch%0d: got %0d, expected 0..%0d",
                       c, d, DIV / 2 + 3);
            end
          end
        end
      end
      prev = irq;
    end
  endtask

  initial begin
    fork
      tx_mon(0);
      tx_mon(1);
      tx_mon(2);
      irq_mon();
    join_none
  end

  initial begin
    repeat (95000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got timeout at %0d, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0] ra, rb, rc, rd2;
    rst_n = 1'b0;
    we = 1'b0;
    re = 1'b0;
    addr = '0;
    wdata = '0;
    rx = 3'b111;

    #23;
    chk("reset_tx", 32'(tx), 32'h7);
    chk("reset_irq", 32'(irq), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      rd(c, 1, 1'b0, d);
      chk($sformatf("reset_status_ch%0d", c), d, 32'h0);
    end
    chk("post_reset_tx", 32'(tx), 32'h7);
    chk("post_reset_irq", 32'(irq), 32'h0);
    wr(3, 2, 32'h5a);
    rd(3, 2, 1'b0, d);
    chk("ch3_reads_zero", d, 32'h0);
    rd(0, 2, 1'b0, d);
    chk("ch0_txdata_reset", d, 32'h0);

    fork
      tx_send(0, 8'h48, 1'b0, 8'h00);
      drive_rx(1, 8'h41, 1'b1, 1'b0, 1'b1);
    join
    chk("irq1_after_frame1", 32'(irq[1]), 32'h1);
    rd(1, 3, 1'b0, d);
    chk("rxdata_0x41", d, 32'h41);
    rd(1, 1, 1'b0, d);
    chk("status_rx_valid", d, 32'h2);

    ra = 8'($urandom);
    rb = 8'($urandom);
    rc = 8'($urandom);
    fork
      tx_send(2, ra, 1'b1, rb);
      drive_rx(1, 8'h4c, 1'b1, 1'b0, 1'b0);
      drive_rx(0, rc, 1'b1, 1'b0, 1'b1);
    join
    rd(1, 1, 1'b0, d);
    chk("status_overrun", d, 32'h6);
    rd(1, 3, 1'b1, d);
    chk("rxdata_0x4c", d, 32'h4c);
    rd(1, 1, 1'b0, d);
    chk("status_cleared", d, 32'h0);
    chk("irq1_cleared", 32'(irq[1]), 32'h0);
    rd(0, 3, 1'b1, d);
    chk("rxdata_rand_ch0", d, {24'd0, rc});
    rd(0, 1, 1'b0, d);
    chk("status_ch0_cleared", d, 32'h0);

    ra = 8'($urandom);
    fork
      tx_send(1, ra, 1'b0, 8'h00);
      drive_rx(2, 8'h55, 1'b0, 1'b0, 1'b1);
    join
    rd(2, 1, 1'b0, d);
    chk("status_frame_err", d, 32'ha);
    rd(2, 3, 1'b0, d);
    chk("rxdata_0x55", d, 32'h55);
    rd(2, 3, 1'b1, d);
    rd(2, 1, 1'b0, d);
    chk("frame_err_cleared", d, 32'h0);
    @(negedge clk);
    rx[2] = 1'b0;
    repeat (100) @(negedge clk);
    rx[2] = 1'b1;
    repeat (1200) @(negedge clk);
    rd(2, 1, 1'b0, d);
    chk("glitch_no_valid", d, 32'h0);

`ifdef UART_HUB_PARITY_EN
    fork
      tx_send(0, 8'h03, 1'b0, 8'h00);
      drive_rx(1, 8'h07, 1'b1, 1'b1, 1'b1);
    join
    rd(1, 1, 1'b0, d);
    chk("status_parity_err", d, 32'h12);
    rd(1, 3, 1'b1, d);
    chk("rxdata_0x07", d, 32'h07);
    rd(1, 1, 1'b0, d);
    chk("parity_err_cleared", d, 32'h0);
`endif

    begin
      int t0;
      wr(0, 2, 32'haa);
      tx_q[0].push_back(tx_frame(8'haa));
      wr(0, 0, 32'd1);
      t0 = cyc;
      wait_until(t0 + 2000);
      wr(0, 2, 32'h11);
      wr(0, 0, 32'd1);
      rd(0, 2, 1'b0, d);
      chk("txdata_0x11", d, 32'h11);
      rd(0, 1, 1'b0, d);
      chk("busy_after_ignored_send", {31'd0, d[0]}, 32'd1);
      wait_until(t0 + 5000);
      rst_n = 1'b0;
      #1 chk("tx_async_reset", 32'(tx[0]), 32'h1);
      rd(0, 1, 1'b0, d);
      chk("status_in_reset", d, 32'h0);
      rd(0, 2, 1'b0, d);
      chk("txdata_in_reset", d, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("tx_idle_after_reset", 32'(tx), 32'h7);
    end

    ra = 8'($urandom);
    rb = 8'($urandom);
    rd2 = 8'($urandom);
    fork
      tx_send(2, ra, 1'b0, 8'h00);
      drive_rx(0, rb, 1'b1, 1'b0, 1'b1);
      drive_rx(1, rd2, 1'b1, 1'b0, 1'b1);
    join
    rd(0, 3, 1'b1, d);
    chk("rxdata_rand2_ch0", d, {24'd0, rb});
    rd(1, 3, 1'b1, d);
    chk("rxdata_rand2_ch1", d, {24'd0, rd2});
    rd(0, 1, 1'b0, d);
    chk("status_rand2_ch0", d, 32'h0);

    repeat (2 * DIV) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("txq_empty_ch%0d", c), tx_q[c].size(), 32'd0);
      chk($sformatf("irqq_empty_ch%0d", c), irq_q[c].size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_hub.md
# uart_hub

Parametrised N-channel UART peripheral for the single-cycle RISC-V SoC. It replaces the fixed three-port UART arrangement with one memory-mapped block. Each channel has a full-duplex 8-bit serial engine, a TX data register, an RX holding register with overrun and frame-error detection, and a per-channel interrupt line. It sits on the processor data bus beside the LED, switch and 7-segment peripherals, and drives the board's tx/rx pins.

## Interface
- `N_CH`, default 3: number of UART channels (1..8).
- `CLK_HZ`, default 100_000_000: system clock frequency.
- `BAUD`, default 115_200: line rate. `DIV = CLK_HZ/BAUD`, integer-truncated, and must be ≥ 16.
- `ADDR_W`, default `$clog2(N_CH)+2`: word-address width.
---
- `clk_100m_i`, in, 1: system clock. All logic is on the rising edge.
- `rst_n_i`, in, 1: asynchronous, active-low reset.
- `we_i`, in, 1: bus write strobe, one cycle.
- `re_i`, in, 1: bus read strobe, one cycle. Read side-effects apply only when this is high.
- `addr_i`, in, `ADDR_W`: word address. `addr_i[ADDR_W-1:2]` is the channel; `addr_i[1:0]` is the register.
- `wdata_i`, in, 32: write data.
- `rdata_o`, out, 32: combinational read data.
- `rx_i`, in, `N_CH`: serial inputs, asynchronous to the clock.
- `tx_o`, out, `N_CH`: serial outputs.
- `irq_o`, out, `N_CH`: per channel, equal to `rx_valid`.

## Operation
- Register map per channel:
  - 0 CTRL (W). Bit 0 = SEND.
  - 1 STATUS (R). Bit 0 = `tx_busy`, bit 1 = `rx_valid`, bit 2 = `rx_overrun`, bit 3 = `frame_err`.
  - 2 TXDATA (R/W, bits [7:0]).
  - 3 RXDATA (R, bits [7:0]).
  - Unused bits read 0. A channel index ≥ `N_CH` reads 0 and ignores writes.
- SEND with `tx_busy`=0 latches TXDATA into the shifter and sets busy. SEND while busy is ignored; the frame in flight is not disturbed.
- A TXDATA write while busy updates the register only. The shifter copy is unaffected.
- TX FSM: IDLE → START → DATA (8 bits, LSB first) → [PARITY] → STOP → IDLE. Every state lasts `DIV` cycles.
- RX path:
  - `rx_i` passes through a 2-flop synchroniser, which adds 2 cycles of latency.
  - RX FSM: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - A falling edge in IDLE enters START. The line is re-sampled at `DIV/2`. If it is high, the event is a glitch and the FSM returns to IDLE with no flags set.
  - Data bits are sampled every `DIV` cycles after that mid-start point.
- Stop-bit handling:
  - Stop sample low: set `frame_err`. The byte is still stored and `rx_valid` is still set.
  - Stop accepted while `rx_valid`=1: RXDATA is overwritten and `rx_overrun` is set.
- RXDATA read with `re_i`=1 clears `rx_valid`, `rx_overrun` and `frame_err` on the next edge. STATUS reads have no side effects.
- If frame completion and an RXDATA read fall in the same cycle, completion wins: `rx_valid` stays 1, the new byte is stored, and overrun is not set.
- Reset values:
  - `tx_o` all 1.
  - `irq_o` 0.
  - All flags 0.
  - TXDATA and RXDATA 0x00.
  - Both FSMs in IDLE.
  - Baud counters 0.
  - Synchronisers preset to 1, so release from reset does not produce a false start.
- Reset asserted mid-frame aborts immediately. `tx_o` returns to 1 asynchronously.

## Timing
- SEND write in cycle t: `tx_o` falls at edge t+1, and `tx_busy` reads 1 from t+1.
- The TX frame is `10·DIV` cycles (`11·DIV` with parity). `tx_busy` clears at the final STOP edge, so a SEND in the next cycle starts back-to-back frames.
- RX: `rx_valid` and `irq_o` rise ≤ `DIV/2 + 3` cycles after the middle of the stop bit.
- Bus reads are zero-wait. A write takes effect at the next edge.

## Configuration
- `UART_HUB_PARITY_EN` defined:
  - Even parity bit inserted after the data bits on TX and checked on RX.
  - A mismatch sets STATUS bit 4, `parity_err`, which is cleared like the other flags.
  - The frame is 11 bits.
- Undefined: no parity state, 10-bit frames, STATUS bit 4 reads 0.

## Structure
- `uart_hub_pkg`:
  - Register offset constants (`REG_CTRL`, `REG_STATUS`, `REG_TXDATA`, `REG_RXDATA`).
  - STATUS bit indices.
  - `tx_state_t` and `rx_state_t` enums.
- Sub-module `uart_hub_ch`: one channel, containing TX/RX FSMs, the synchroniser, the data registers and the flags. It is instantiated `N_CH` times in a generate loop.
- Top level: address decode and the read mux.

## Test plan
All scenarios use `CLK_HZ`=100e6 and `BAUD`=115200, so `DIV`=868.
- **Reset defaults:** hold `rst_n_i`=0, then release. Required: `tx_o`=3'b111, `irq_o`=0, STATUS reads 0 for every channel, and no false RX start.
- **Transmit:** write 0x48 to ch0 TXDATA, then CTRL=1. Required: `tx_o[0]` carries 0,0,0,0,1,0,0,1,0,1, each bit 868 cycles. `tx_busy` is 1 for 8680 cycles, then 0.
- **Receive plus overrun:** drive 0x41 then 0x4C on `rx_i[1]`. Required: after frame 1, `irq_o[1]`=1 and RXDATA=0x41. After frame 2, RXDATA=0x4C and `rx_overrun`=1. Reading RXDATA then clears all flags and `irq_o[1]`.
- **Framing and glitch:** drive frame 0x55 with the stop bit low on ch2. Required: `frame_err`=1 and RXDATA=0x55. Then a 100-cycle low pulse yields no `rx_valid`.
- **Busy SEND and reset mid-frame:** SEND 0xAA, then at cycle 2000 write TXDATA=0x11 and SEND. Required: the line still carries 0xAA. Assert reset at cycle 5000: `tx_o[0]`=1 immediately and `tx_busy`=0.
- **Parity (build with `UART_HUB_PARITY_EN`):**
  - TX 0x03. Required: parity bit 0, then stop.
  - RX 0x07 with parity bit 0. Required: `parity_err`=1.
